// File: rtl/screen_timing_pkg.sv
// Shared raster timing constants for the 640x480 display path.
// The pixel/sprite logic and screen_timing both pull their geometry from here.
package screen_timing_pkg;

   localparam int COORD_W = 10;
   localparam int FRAME_W = 16;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Sync pulse sits right after the front porch; end is exclusive.
   function automatic int sync_start(input int act, input int fp);
      return act + fp;
   endfunction

   function automatic int sync_end(input int act, input int fp, input int sync);
      return act + fp + sync;
   endfunction

   localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
   localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
   localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
   localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/screen_timing_mod_counter.sv
// Modulo-N counter with enable; wrap is a combinational look-ahead so the
// next counter in a chain advances on the same edge this one returns to 0.
module mod_counter
   import screen_timing_pkg::*;
#(
   parameter int WIDTH   = COORD_W,
   parameter int MODULUS = DEF_H_TOTAL
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   assign wrap = en && (count == LAST);

   // NOTE: state registers use non-blocking assignments so every counter in
   // the chain samples the pre-edge values of the others.
   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (wrap)
         count <= '0;
      else if (en)
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/screen_timing.sv
// VGA-style raster generator: half-rate pixel enable, x/y position counters,
// active-low syncs, an end-of-visible-frame pulse and a frame counter.
module screen_timing
   import screen_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic               clock,
   input  logic               reset,
   output logic               hsync,
   output logic               vsync,
   output logic               active,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               screen_end,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_ACT_W = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_W = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(sync_start(H_ACTIVE, H_FP));
   localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(sync_start(V_ACTIVE, V_FP));
   localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

   logic divider;
   logic pix_tick;
   logic x_wrap;
   logic y_wrap;

   // Pixel rate is half the system clock; divider acts as an enable, never a clock.
   always_ff @(posedge clock) begin
      if (reset)
         divider <= 1'b0;
      else
         divider <= ~divider;
   end

   assign pix_tick = divider;

   mod_counter #(.WIDTH(COORD_W), .MODULUS(H_TOTAL)) u_x_count (
      .clock (clock),
      .reset (reset),
      .en    (pix_tick),
      .count (x),
      .wrap  (x_wrap)
   );

   mod_counter #(.WIDTH(COORD_W), .MODULUS(V_TOTAL)) u_y_count (
      .clock (clock),
      .reset (reset),
      .en    (x_wrap),
      .count (y),
      .wrap  (y_wrap)
   );

   always_ff @(posedge clock) begin
      if (reset)
         frame_count <= '0;
      else if (y_wrap)
         frame_count <= frame_count + FRAME_W'(1);
   end

   assign active = (x < H_ACT_W) && (y < V_ACT_W);
   assign hsync  = !((x >= HS_LO) && (x < HS_HI));
   assign vsync  = !((y >= VS_LO) && (y < VS_HI));

   // Only the first of the two clocks spent at (0, V_ACTIVE) has divider low,
   // which makes the pulse exactly one clock wide.
   assign screen_end = (x == '0) && (y == V_ACT_W) && !divider;

endmodule

// File: tb/tb_screen_timing.sv
// Bench for screen_timing: a default-geometry instance for line-level timing
// and a shrunken-geometry instance for whole frames, both held to a time-based model.
module tb_screen_timing;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] fc;
      logic        act;
      logic        hs;
      logic        vs;
      logic        se;
   } obs_t;

   typedef struct packed {
      obs_t d;
      obs_t s;
   } exp_t;

   typedef struct packed {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
   } cfg_t;

   localparam cfg_t CFG_D = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
   localparam cfg_t CFG_S = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1};

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       hsync_d, vsync_d, active_d, se_d;
   logic [9:0] x_d, y_d;
   logic [15:0] fc_d;
   logic       hsync_s, vsync_s, active_s, se_s;
   logic [9:0] x_s, y_s;
   logic [15:0] fc_s;

   obs_t got_d, got_s;
   assign got_d = {x_d, y_d, fc_d, active_d, hsync_d, vsync_d, se_d};
   assign got_s = {x_s, y_s, fc_s, active_s, hsync_s, vsync_s, se_s};

   int total = 0;
   int bad   = 0;
   int t      = 0;
   int base_s = 0;
   int se_seen = 0;
   int se_exp  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   screen_timing dut_def (
      .clock       (clk),
      .reset       (reset),
      .hsync       (hsync_d),
      .vsync       (vsync_d),
      .active      (active_d),
      .x           (x_d),
      .y           (y_d),
      .screen_end  (se_d),
      .frame_count (fc_d)
   );

   screen_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_sm (
      .clock       (clk),
      .reset       (reset),
      .hsync       (hsync_s),
      .vsync       (vsync_s),
      .active      (active_s),
      .x           (x_s),
      .y           (y_s),
      .screen_end  (se_s),
      .frame_count (fc_s)
   );

   // Expected outputs t clocks after the last reset edge.
   function automatic obs_t model(input cfg_t c, input int tt, input int base);
      int ht   = c.ha + c.hf + c.hs + c.hb;
      int vt   = c.va + c.vf + c.vs + c.vb;
      int pix  = tt / 2;
      int xi   = pix % ht;
      int line = pix / ht;
      int yi   = line % vt;
      int fr   = (base + line / vt) % 65536;
      obs_t o;
      o.x   = 10'(xi);
      o.y   = 10'(yi);
      o.fc  = 16'(fr);
      o.act = (xi < c.ha) && (yi < c.va);
      o.hs  = !((xi >= c.ha + c.hf) && (xi < c.ha + c.hf + c.hs));
      o.vs  = !((yi >= c.va + c.vf) && (yi < c.va + c.vf + c.vs));
      o.se  = (xi == 0) && (yi == c.va) && (tt % 2 == 0);
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Drive one clock with the given reset level and compare both instances.
   task automatic step(input logic rst);
      exp_t e;
      reset = rst;
      if (rst) begin
         t      = 0;
         base_s = 0;
      end else begin
         t++;
      end
      e.d = model(CFG_D, t, 0);
      e.s = model(CFG_S, t, base_s);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check("def_cycle", 64'(got_d), 64'(e.d));
      check("sml_cycle", 64'(got_s), 64'(e.s));
      if (se_s) se_seen++;
      if (e.s.se) se_exp++;
   endtask

   initial begin
      int hs_cnt   = 0;
      int vs_cnt   = 0;
      int hs_first = -1;
      int max_x = 0, max_y = 0, max_xd = 0, max_yd = 0;

      // Reset state
      repeat (3) step(1'b1);
      check("reset_state", 64'(got_s), 64'({10'd0, 10'd0, 16'd0, 4'b1110}));

      // Free run: line-level timing on the default geometry
      for (int i = 0; i < 1700; i++) begin
         step(1'b0);
         if (t == 1) check("x_hold_clk1", 64'(x_d), 64'd0);
         if (t == 2) check("x_first_inc", 64'(x_d), 64'd1);
         if (t == 1279) check("active_before_640", 64'(active_d), 64'd1);
         if (t == 1280) check("active_fall_640", 64'(active_d), 64'd0);
         if (t == 1599) check("line_end_xy", 64'({x_d, y_d}), 64'({10'd799, 10'd0}));
         if (t == 1600) check("line_wrap_xy", 64'({x_d, y_d}), 64'({10'd0, 10'd1}));
         if (y_d == 10'd0 && !hsync_d) begin
            if (hs_first < 0) hs_first = int'(x_d);
            hs_cnt++;
         end
         if (t < 300 && !vsync_s) vs_cnt++;
      end
      check("hsync_low_clocks", 64'(hs_cnt), 64'd192);
      check("hsync_first_x", 64'(hs_first), 64'd656);
      check("vsync_low_clocks", 64'(vs_cnt), 64'd60);
      check("frames_after_run", 64'(fc_s), 64'd5);

      // Reset during both sync pulses aborts the frame
      step(1'b1);
      for (int i = 0; i < 232; i++) step(1'b0);
      check("in_sync_pos", 64'({x_s, y_s, hsync_s, vsync_s}), 64'({10'd11, 10'd7, 2'b00}));
      step(1'b1);
      check("sync_reset", 64'(got_s), 64'({10'd0, 10'd0, 16'd0, 4'b1110}));

      // Reset during the screen_end clock
      for (int i = 0; i < 180; i++) step(1'b0);
      check("se_high", 64'(se_s), 64'd1);
      step(1'b1);
      check("se_reset", 64'({se_s, fc_s}), 64'({1'b0, 16'd0}));
      for (int i = 0; i < 200; i++) step(1'b0);
      check("fc_after_abort", 64'(fc_s), 64'd0);

      // Frame counter wrap 65535 -> 0
      step(1'b1);
      force dut_sm.frame_count = 16'hFFFF;
      #1;
      release dut_sm.frame_count;
      base_s = 65535;
      for (int i = 0; i < 300; i++) begin
         step(1'b0);
         if (t == 299) check("fc_preload", 64'(fc_s), 64'hFFFF);
      end
      check("fc_wrap", 64'({fc_s, x_s, y_s, active_s}), 64'({16'd0, 10'd0, 10'd0, 1'b1}));

      // Random reset pulses over about three frames
      se_seen = 0;
      se_exp  = 0;
      for (int i = 0; i < 900; i++) begin
         step($urandom_range(0, 49) == 0);
         if (int'(x_s) > max_x) max_x = int'(x_s);
         if (int'(y_s) > max_y) max_y = int'(y_s);
         if (int'(x_d) > max_xd) max_xd = int'(x_d);
         if (int'(y_d) > max_yd) max_yd = int'(y_d);
      end
      check("range_sml", 64'({max_x < 15, max_y < 10}), 64'(2'b11));
      check("range_def", 64'({max_xd < 800, max_yd < 525}), 64'(2'b11));
      check("se_count", 64'(se_seen), 64'(se_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
